// File: rtl/register_access_arbiter_pkg.sv
// Shared definitions for the register access arbiter.
//   FS_*         FunSel codes understood by the shared 16-bit Register
//   arb_state_t  arbiter state: IDLE (no issue), ISSUE (RegE=1), LOCKED
//                (grant held by one requester; lock build only)
package reg_arb_pkg;

  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD   = 3'b010;
  localparam logic [2:0] FS_CLR    = 3'b011;
  localparam logic [2:0] FS_LOADL  = 3'b100;
  localparam logic [2:0] FS_LOADLK = 3'b101;
  localparam logic [2:0] FS_LOADH  = 3'b110;
  localparam logic [2:0] FS_SEXT   = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/register_access_arbiter_if.sv
// Handshake/bus bundle between the requesters, the arbiter and the Register.
//   req          per-requester op request, held until ack
//   req_fun_sel  FunSel for requester k at [3k+2:3k]
//   req_data     I value for requester k at [DATA_W*k +: DATA_W]
//   req_lock     hold grant after this op (lock build only)
//   ack          one-hot pulse: op of requester k issued this cycle
//   grant_id     index of requester issued this cycle (held while idle)
//   busy         high whenever reg_e is high
//   reg_e / reg_fun_sel / reg_i   drive Register.E / FunSel / I
// Modports: master = requester side, slave = arbiter side.
interface register_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [3*NUM_REQ-1:0]      req_fun_sel;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        ack;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
  logic                      reg_e;
  logic [2:0]                reg_fun_sel;
  logic [DATA_W-1:0]         reg_i;

  modport master (
    output req, req_fun_sel, req_data, req_lock,
    input  ack, grant_id, busy, reg_e, reg_fun_sel, reg_i
  );

  modport slave (
    input  req, req_fun_sel, req_data, req_lock,
    output ack, grant_id, busy, reg_e, reg_fun_sel, reg_i
  );

endinterface

// File: rtl/register_access_arbiter_rr_pick.sv
// Combinational rotate-priority selector.
//   eligible_i  requesters that may be granted this edge
//   ptr_i       last granted index; search starts at ptr_i+1 and wraps
//   valid_o     at least one eligible requester
//   winner_o    first eligible index after ptr_i (ptr_i itself is lowest)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   winner_o
);

  // Scan from farthest to nearest so the nearest eligible index is written last.
  always_comb begin
    int idx;
    idx      = 0;
    valid_o  = 1'b0;
    winner_o = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (eligible_i[idx[IDX_W-1:0]]) begin
        valid_o  = 1'b1;
        winner_o = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/register_access_arbiter.sv
// Round-robin arbiter sharing one Register (E/FunSel/I) among NUM_REQ
// requesters. One op is issued per cycle at most; all outputs are registered.
//   clk_i  clock, rising edge
//   rst_i  asynchronous, active-high reset
//   bus    register_access_arbiter_if.slave (requests in, ack/grant/Register drive out)
// Build option: define REG_ARB_LOCK_EN to let a requester hold the grant via
// req_lock for up to LOCK_MAX consecutive ops. Without it req_lock is ignored.
module register_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input logic                      clk_i,
  input logic                      rst_i,
  register_access_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                reg_e_q, reg_e_d;
  logic [2:0]          fun_q, fun_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;

  logic [NUM_REQ-1:0]  elig;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

`ifdef REG_ARB_LOCK_EN
  // While locked the pointer always equals the lock owner, since only the
  // owner can be granted. Owner dropping Req releases the lock at that edge.
  logic lock_hold;
  assign lock_hold = (state_q == LOCKED) && bus.req[ptr_q];
`else
  logic lock_unused;
  assign lock_unused = ^{bus.req_lock, lock_cnt_q, state_q};
`endif

  // A requester acked this cycle still holds Req (or presents its next op),
  // so it is masked for one edge to avoid a double issue.
  always_comb begin
    elig = bus.req & ~ack_q;
`ifdef REG_ARB_LOCK_EN
    if (lock_hold) begin
      elig = elig & (NUM_REQ'(1) << ptr_q);
    end
`endif
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible_i (elig),
    .ptr_i      (ptr_q),
    .valid_o    (pick_valid),
    .winner_o   (pick_idx)
  );

  always_comb begin
    state_d    = IDLE;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    reg_e_d    = 1'b0;
    fun_d      = fun_q;
    data_d     = data_q;
    lock_cnt_d = lock_cnt_q;
    if (pick_valid) begin
      state_d         = ISSUE;
      ptr_d           = pick_idx;
      grant_d         = pick_idx;
      ack_d[pick_idx] = 1'b1;
      reg_e_d         = 1'b1;
      fun_d           = bus.req_fun_sel[3*pick_idx +: 3];
      data_d          = bus.req_data[DATA_W*pick_idx +: DATA_W];
`ifdef REG_ARB_LOCK_EN
      // The op that enters the lock counts; the LOCK_MAX-th op forces release.
      lock_cnt_d = '0;
      if (bus.req_lock[pick_idx] && (int'(lock_cnt_q) + 1 < LOCK_MAX)) begin
        state_d    = LOCKED;
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
`endif
    end else begin
`ifdef REG_ARB_LOCK_EN
      if (lock_hold) begin
        state_d = LOCKED;
      end else begin
        lock_cnt_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      reg_e_q    <= 1'b0;
      fun_q      <= '0;
      data_q     <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      reg_e_q    <= reg_e_d;
      fun_q      <= fun_d;
      data_q     <= data_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = reg_e_q;
  assign bus.reg_e       = reg_e_q;
  assign bus.reg_fun_sel = fun_q;
  assign bus.reg_i       = data_q;

endmodule

// File: tb/tb_register_access_arbiter.sv
module tb_register_access_arbiter;
  import reg_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_access_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  register_access_arbiter #(.NUM_REQ(N), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [2:0] fs;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   hold[N];
  bit   rnd_mode = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Attached Register, updated whenever the arbiter asserts E.
  logic [15:0] treg;
  always @(posedge clk or posedge rst) begin
    if (rst) treg <= 16'h0000;
    else if (bus.reg_e) begin
      case (bus.reg_fun_sel)
        FS_DEC:    treg <= treg - 16'd1;
        FS_INC:    treg <= treg + 16'd1;
        FS_LOAD:   treg <= bus.reg_i;
        FS_CLR:    treg <= 16'h0000;
        FS_LOADL:  treg <= {treg[15:8], bus.reg_i[7:0]};
        FS_LOADLK: treg <= {8'h00, bus.reg_i[7:0]};
        FS_LOADH:  treg <= {bus.reg_i[7:0], treg[7:0]};
        default:   treg <= {{8{bus.reg_i[7]}}, bus.reg_i[7:0]};
      endcase
    end
  end

  // Reference model: per edge, candidates are requesting and not acked in the
  // previous cycle; winner is the nearest candidate after the last winner.
  int         m_ptr, m_last_grant, m_lock_owner, m_lock_cnt, m_w;
  logic [3:0] m_prev_ack, m_cand;
  exp_t       m_e;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = N - 1; m_last_grant = 0; m_lock_owner = -1; m_lock_cnt = 0;
      m_prev_ack = '0;
      exp_q.delete();
    end else begin
      m_cand = bus.req & ~m_prev_ack;
`ifdef REG_ARB_LOCK_EN
      if (m_lock_owner >= 0 && !bus.req[2'(m_lock_owner)]) begin
        m_lock_owner = -1; m_lock_cnt = 0;
      end
      if (m_lock_owner >= 0) m_cand = m_cand & (4'b0001 << m_lock_owner);
`endif
      m_w = -1;
      for (int d = 1; d <= N; d++)
        if (m_w < 0 && m_cand[2'((m_ptr + d) % N)]) m_w = (m_ptr + d) % N;
      m_prev_ack = '0;
      if (m_w >= 0) begin
        m_e.id = m_w;
        m_e.fs = bus.req_fun_sel[3*m_w +: 3];
        m_e.d  = bus.req_data[DW*m_w +: DW];
        exp_q.push_back(m_e);
        m_prev_ack[2'(m_w)] = 1'b1;
        m_ptr = m_w;
        m_last_grant = m_w;
`ifdef REG_ARB_LOCK_EN
        if (bus.req_lock[2'(m_w)]) begin
          m_lock_cnt++;
          if (m_lock_cnt >= LM) begin m_lock_owner = -1; m_lock_cnt = 0; end
          else m_lock_owner = m_w;
        end else begin
          m_lock_owner = -1; m_lock_cnt = 0;
        end
`endif
      end
    end
  end

  // Monitor: pops one expectation per presented issue.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_e) grant_log.push_back(int'(bus.grant_id));
      if (bus.reg_e || exp_q.size() > 0) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_issue", 32'(bus.reg_e), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_reg_e",   32'(bus.reg_e), 32'd1);
          chk("sb_grant",   32'(bus.grant_id), 32'(mon_e.id));
          chk("sb_ack",     32'(bus.ack), 32'd1 << mon_e.id);
          chk("sb_funsel",  32'(bus.reg_fun_sel), 32'(mon_e.fs));
          chk("sb_data",    32'(bus.reg_i), 32'(mon_e.d));
          chk("sb_busy",    32'(bus.busy), 32'd1);
        end
      end else begin
        chk("idle_ack",   32'(bus.ack), 32'd0);
        chk("idle_busy",  32'(bus.busy), 32'd0);
        chk("grant_hold", 32'(bus.grant_id), 32'(m_last_grant));
      end
    end
  end

  task automatic set_op(int k, logic [2:0] fs, logic [15:0] d, logic lk);
    bus.req_fun_sel[3*k +: 3] = fs;
    bus.req_data[DW*k +: DW]  = d;
    bus.req_lock[2'(k)]       = lk;
    bus.req[2'(k)]            = 1'b1;
  endtask

  task automatic new_op(int k);
    logic lk;
`ifdef REG_ARB_LOCK_EN
    lk = ($urandom_range(3, 0) == 0);
`else
    lk = $urandom_range(1, 0) == 1;
`endif
    set_op(k, 3'($urandom_range(7, 0)), 16'($urandom), lk);
  endtask

  // One clock: requesters that saw Ack drop or present their next op.
  task automatic cycle();
    logic [3:0] a;
    a = bus.ack;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (bus.req[2'(k)] && a[2'(k)] && !hold[k]) begin
        if (rnd_mode && $urandom_range(1, 0) == 1) new_op(k);
        else bus.req[2'(k)] = 1'b0;
      end else if (rnd_mode && !bus.req[2'(k)] && $urandom_range(2, 0) == 0) begin
        new_op(k);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    bus.req = '0;
    for (int k = 0; k < N; k++) hold[k] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    grant_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0; bus.req_fun_sel = '0; bus.req_data = '0; bus.req_lock = '0;
    for (int k = 0; k < N; k++) hold[k] = 1'b0;

    // T1: reset values, mid-issue reset, first grant after release
    @(posedge clk); #1;
    chk("rst_reg_e",  32'(bus.reg_e), 32'd0);
    chk("rst_ack",    32'(bus.ack), 32'd0);
    chk("rst_grant",  32'(bus.grant_id), 32'd0);
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_funsel", 32'(bus.reg_fun_sel), 32'd0);
    chk("rst_reg_i",  32'(bus.reg_i), 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    set_op(0, FS_LOAD, 16'h1234, 1'b0);
    @(posedge clk); #2;
    chk("t1_rege_pre", 32'(bus.reg_e), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_rege_async", 32'(bus.reg_e), 32'd0);
    chk("t1_ack_async",  32'(bus.ack), 32'd0);
    chk("t1_busy_async", 32'(bus.busy), 32'd0);
    bus.req = '0;
    @(posedge clk); #3 rst = 1'b0;
    set_op(0, FS_LOAD, 16'h5678, 1'b0);
    cycle();
    chk("t1_ack",   32'(bus.ack), 32'h1);
    chk("t1_grant", 32'(bus.grant_id), 32'd0);
    repeat (2) cycle();

    // T2: all four request at once -> 0,1,2,3 back to back
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, FS_LOAD, 16'(16'hA000 + k), 1'b0);
    repeat (5) cycle();
    chk("t2_len", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("t2_order", 32'(grant_log[i]), 32'(i));

    // T3: single held requester issues every second cycle
    do_reset();
    hold[2] = 1'b1;
    set_op(2, FS_INC, 16'h0000, 1'b0);
    repeat (6) cycle();
    hold[2] = 1'b0;
    bus.req[2] = 1'b0;
    chk("t3_count", 32'(grant_log.size()), 32'd3);
    chk("t3_reg",   32'(treg), 32'h0003);
    repeat (2) cycle();

    // T4: payload routing, two requesters same edge
    do_reset();
    set_op(1, FS_LOAD,  16'hBEEF, 1'b0);
    set_op(3, FS_LOADH, 16'h0012, 1'b0);
    repeat (3) cycle();
    chk("t4_reg", 32'(treg), 32'h12EF);
    chk("t4_len", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("t4_first",  32'(grant_log[0]), 32'd1);
      chk("t4_second", 32'(grant_log[1]), 32'd3);
    end

    // T5: req0 asks for lock, req1 pending
    do_reset();
    hold[0] = 1'b1; hold[1] = 1'b1;
    set_op(0, FS_INC, 16'h0A0A, 1'b1);
    set_op(1, FS_DEC, 16'h0B0B, 1'b0);
    repeat (10) cycle();
    hold[0] = 1'b0; hold[1] = 1'b0;
    bus.req = '0;
    chk("t5_len", 32'(grant_log.size() >= 5), 32'd1);
    if (grant_log.size() >= 5) begin
`ifdef REG_ARB_LOCK_EN
      chk("t5_g0", 32'(grant_log[0]), 32'd0);
      chk("t5_g1", 32'(grant_log[1]), 32'd0);
      chk("t5_g2", 32'(grant_log[2]), 32'd0);
      chk("t5_g3", 32'(grant_log[3]), 32'd0);
      chk("t5_g4", 32'(grant_log[4]), 32'd1);
`else
      chk("t5_g0", 32'(grant_log[0]), 32'd0);
      chk("t5_g1", 32'(grant_log[1]), 32'd1);
      chk("t5_g2", 32'(grant_log[2]), 32'd0);
      chk("t5_g3", 32'(grant_log[3]), 32'd1);
      chk("t5_g4", 32'(grant_log[4]), 32'd0);
`endif
    end
    repeat (2) cycle();

    // T6: pointer at 3, requests on 0 and 3 -> wrap to 0 first
    do_reset();
    set_op(3, FS_CLR, 16'h0000, 1'b0);
    repeat (3) cycle();
    set_op(0, FS_LOAD, 16'h00C0, 1'b0);
    set_op(3, FS_LOAD, 16'h00C3, 1'b0);
    repeat (4) cycle();
    chk("t6_len", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      chk("t6_g0", 32'(grant_log[0]), 32'd3);
      chk("t6_g1", 32'(grant_log[1]), 32'd0);
      chk("t6_g2", 32'(grant_log[2]), 32'd3);
    end

    // Random traffic against the model
    do_reset();
    rnd_mode = 1'b1;
    repeat (800) cycle();
    rnd_mode = 1'b0;
    bus.req = '0;
    repeat (3) cycle();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
